// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Instruction fetch controller. Fetches the word at the current
//                PC over a req/gnt + rvalid memory port, holds it for decode,
//                and pulses the PC register write-enable on decode handshake
//                or branch flush. Detects response timeout and misaligned PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter int          WAIT_MAX  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_pc_wren,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_id_ready,
    output logic        o_fetch_err,
    output logic [31:0] o_fetch_cnt
);

    localparam int TW = $clog2(WAIT_MAX + 1);
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(WAIT_MAX - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [TW-1:0] r_timer;
    logic          r_drop;
    logic [31:0]   r_instr;
    logic          r_instr_valid;
    logic          r_fetch_err;
    logic [31:0]   r_fetch_cnt;
    logic          w_pc_wren;
    logic          w_req;
    logic          w_misalign;
    logic          w_handshake;

    assign w_misalign  = |i_pc[1:0];
    // Decode acceptance counts only when no flush kills the held word.
    assign w_handshake = (r_state == S_HOLD) && r_instr_valid && i_id_ready && !i_flush;

    assign o_imem_addr   = {i_pc[31:2], 2'b00};
    assign o_imem_req    = w_req & ~i_rst;
    assign o_pc_wren     = w_pc_wren & ~i_rst;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_fetch_err   = r_fetch_err;
    assign o_fetch_cnt   = r_fetch_cnt;

    // Next-state, memory request and PC write-enable decode.
    always_comb begin
        w_next_state = r_state;
        w_pc_wren    = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_wren    = i_flush;
                w_next_state = S_REQ;
            end
            S_REQ: begin
                if (i_flush) begin
                    // A redirect supersedes the stale (possibly misaligned) PC;
                    // a grant in this cycle still leaves a response to drop.
                    w_pc_wren = 1'b1;
                    w_req     = !w_misalign;
                    if (!w_misalign && i_imem_gnt) begin
                        w_next_state = S_WAIT;
                    end
                end else if (w_misalign) begin
                    w_next_state = S_ERR;
                end else begin
                    w_req = 1'b1;
                    if (i_imem_gnt) begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_pc_wren = i_flush;
                if (i_imem_rvalid) begin
                    w_next_state = (r_drop || i_flush) ? S_REQ : S_HOLD;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_next_state = S_ERR;
                end
            end
            S_HOLD: begin
                w_pc_wren = i_flush | i_id_ready;
                if (i_flush || i_id_ready) begin
                    w_next_state = S_REQ;
                end
            end
            S_ERR: begin
                w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, response capture, drop flag, timeout timer and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_drop        <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_cnt   <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_REQ && w_next_state == S_WAIT) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end

            // Only one request is outstanding, so any response in WAIT
            // retires the drop flag.
            if (r_state == S_WAIT && i_imem_rvalid) begin
                r_drop <= 1'b0;
            end else if (i_flush && ((r_state == S_REQ && w_next_state == S_WAIT) ||
                                     r_state == S_WAIT)) begin
                r_drop <= 1'b1;
            end

            if (r_state == S_WAIT && w_next_state == S_HOLD) begin
                r_instr       <= i_imem_rdata;
                r_instr_valid <= 1'b1;
            end else if (r_state == S_HOLD && (i_flush || i_id_ready)) begin
                r_instr       <= NOP_INSTR;
                r_instr_valid <= 1'b0;
            end

            if (w_next_state == S_ERR) begin
                r_fetch_err <= 1'b1;
            end

            if (w_handshake) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Directed self-checking bench for instr_fetch_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam logic [31:0] C_NOP = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_pc_wren;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_id_ready;
    logic        o_fetch_err;
    logic [31:0] o_fetch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_ctrl #(
        .WAIT_MAX  (16),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc          (i_pc),
        .i_flush       (i_flush),
        .o_pc_wren     (o_pc_wren),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_id_ready    (i_id_ready),
        .o_fetch_err   (o_fetch_err),
        .o_fetch_cnt   (o_fetch_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after the edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Settle combinational outputs after input changes before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_pc = 32'h0; i_flush = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0; i_id_ready = 1'b0;

        // T1 reset
        cyc(); cyc(); settle();
        chk("rst_req",   {31'h0, o_imem_req},    32'd0);
        chk("rst_wren",  {31'h0, o_pc_wren},     32'd0);
        chk("rst_instr", o_instr,                C_NOP);
        chk("rst_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("rst_err",   {31'h0, o_fetch_err},   32'd0);
        chk("rst_cnt",   o_fetch_cnt,            32'd0);

        // T2 basic fetch at PC 0
        i_rst = 1'b0;
        cyc();                               // IDLE -> REQ
        i_imem_gnt = 1'b1; settle();
        chk("t2_req",  {31'h0, o_imem_req}, 32'd1);
        chk("t2_addr", o_imem_addr,         32'h0);
        cyc();                               // -> WAIT
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h00500093; settle();
        chk("t2_wait_req", {31'h0, o_imem_req}, 32'd0);
        cyc();                               // -> HOLD
        i_imem_rvalid = 1'b0; settle();
        chk("t2_valid", {31'h0, o_instr_valid}, 32'd1);
        chk("t2_instr", o_instr,                32'h00500093);
        chk("t2_wren0", {31'h0, o_pc_wren},     32'd0);
        i_id_ready = 1'b1; settle();
        chk("t2_wren1", {31'h0, o_pc_wren},     32'd1);
        cyc();                               // -> REQ
        i_id_ready = 1'b0; i_pc = 32'h4; settle();
        chk("t2_wren_end", {31'h0, o_pc_wren},     32'd0);
        chk("t2_valid_end",{31'h0, o_instr_valid}, 32'd0);
        chk("t2_instr_end",o_instr,                C_NOP);
        chk("t2_cnt",      o_fetch_cnt,            32'd1);

        // T3 decode stall
        chk("t3_addr", o_imem_addr, 32'h4);
        i_imem_gnt = 1'b1;
        cyc();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h00A00113;
        cyc();
        i_imem_rvalid = 1'b0; settle();
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_instr", o_instr,            32'h00A00113);
            chk("t3_stall_wren",  {31'h0, o_pc_wren}, 32'd0);
            cyc();
        end
        i_id_ready = 1'b1; settle();
        chk("t3_wren1", {31'h0, o_pc_wren}, 32'd1);
        cyc();
        i_id_ready = 1'b0; i_pc = 32'h8; settle();
        chk("t3_wren_pulse", {31'h0, o_pc_wren}, 32'd0);
        chk("t3_cnt",        o_fetch_cnt,        32'd2);

        // T4 flush in WAIT, stale response dropped
        i_imem_gnt = 1'b1;
        cyc();                               // -> WAIT
        i_imem_gnt = 1'b0; i_flush = 1'b1; settle();
        chk("t4_flush_wren", {31'h0, o_pc_wren}, 32'd1);
        cyc();                               // stay WAIT, drop set
        i_flush = 1'b0; i_pc = 32'h40;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEADBEEF;
        cyc();                               // discarded -> REQ
        i_imem_rvalid = 1'b0; settle();
        chk("t4_no_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("t4_no_instr", o_instr,                C_NOP);
        chk("t4_req",      {31'h0, o_imem_req},    32'd1);
        chk("t4_addr",     o_imem_addr,            32'h40);
        i_imem_gnt = 1'b1;
        cyc();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h00100193;
        cyc();
        i_imem_rvalid = 1'b0; settle();
        chk("t4_instr", o_instr,     32'h00100193);
        chk("t4_cnt",   o_fetch_cnt, 32'd2);
        i_id_ready = 1'b1;
        cyc();
        i_id_ready = 1'b0; i_pc = 32'h44; settle();
        chk("t4_cnt2", o_fetch_cnt, 32'd3);

        // Flush in HOLD beats a simultaneous decode accept
        i_imem_gnt = 1'b1;
        cyc();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h12345678;
        cyc();
        i_imem_rvalid = 1'b0; i_flush = 1'b1; i_id_ready = 1'b1; settle();
        chk("t4h_wren", {31'h0, o_pc_wren}, 32'd1);
        cyc();
        i_flush = 1'b0; i_id_ready = 1'b0; i_pc = 32'h80; settle();
        chk("t4h_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("t4h_cnt",   o_fetch_cnt,            32'd3);
        chk("t4h_req",   {31'h0, o_imem_req},    32'd1);

        // T6 reset in WAIT, late response ignored
        i_imem_gnt = 1'b1;
        cyc();
        i_imem_gnt = 1'b0; i_rst = 1'b1;
        cyc();                               // -> IDLE
        i_rst = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0BAD0; settle();
        chk("t6_cnt",       o_fetch_cnt,         32'd0);
        chk("t6_idle_req",  {31'h0, o_imem_req}, 32'd0);
        cyc();                               // -> REQ, response ignored
        i_imem_rvalid = 1'b0; settle();
        chk("t6_late_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("t6_req",        {31'h0, o_imem_req},    32'd1);
        // Reset in HOLD
        i_imem_gnt = 1'b1;
        cyc();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h00000093;
        cyc();
        i_imem_rvalid = 1'b0; settle();
        chk("t6_hold_valid", {31'h0, o_instr_valid}, 32'd1);
        i_rst = 1'b1;
        cyc();
        settle();
        chk("t6_hrst_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("t6_hrst_instr", o_instr,                C_NOP);
        chk("t6_hrst_req",   {31'h0, o_imem_req},    32'd0);
        i_rst = 1'b0;
        cyc();                               // -> REQ

        // T5a misaligned PC
        i_pc = 32'h00000002; settle();
        chk("t5_mis_req", {31'h0, o_imem_req}, 32'd0);
        cyc();                               // -> ERR
        i_pc = 32'h0; i_imem_gnt = 1'b1; settle();
        chk("t5_mis_err", {31'h0, o_fetch_err}, 32'd1);
        cyc(); cyc(); settle();
        chk("t5_mis_sticky", {31'h0, o_fetch_err}, 32'd1);
        chk("t5_err_req",    {31'h0, o_imem_req},  32'd0);
        i_imem_gnt = 1'b0; i_rst = 1'b1;
        cyc();
        i_rst = 1'b0; settle();
        chk("t5_err_clr", {31'h0, o_fetch_err}, 32'd0);
        cyc();                               // -> REQ

        // T5b response timeout
        i_imem_gnt = 1'b1;
        cyc();                               // -> WAIT
        i_imem_gnt = 1'b0;
        for (int k = 0; k < 15; k++) cyc();
        chk("t5_to_early", {31'h0, o_fetch_err}, 32'd0);
        cyc();
        chk("t5_to_err", {31'h0, o_fetch_err}, 32'd1);
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h11111111;
        cyc();
        i_imem_rvalid = 1'b0; settle();
        chk("t5_to_novalid", {31'h0, o_instr_valid}, 32'd0);
        chk("t5_to_sticky",  {31'h0, o_fetch_err},   32'd1);
        i_rst = 1'b1;
        cyc();
        settle();
        chk("t5_to_clr", {31'h0, o_fetch_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
